// File: rtl/lcd_ctrl.sv
// 4-bit character LCD sequencer: power-on init, then valid/ready command/data bytes
// split into high/low nibble strobes with programmable setup/enable/hold/gap/wait timing.
module lcd_ctrl #(
  parameter int T_PWRON  = 750000,
  parameter int T_SETUP  = 2,
  parameter int T_EHIGH  = 12,
  parameter int T_HOLD   = 1,
  parameter int T_NIBGAP = 50,
  parameter int T_CMD    = 2000,
  parameter int T_CLEAR  = 82000,
  parameter int T_INIT1  = 205000,
  parameter int T_INIT2  = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] sf_d
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(max2(T_PWRON, T_SETUP), max2(T_EHIGH, T_HOLD)),
                             max2(max2(T_NIBGAP, T_CMD), max2(max2(T_CLEAR, T_INIT1), T_INIT2)));
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [3:0] {
    S_PWRON, S_SETUP_H, S_E_H, S_HOLD_H, S_GAP,
    S_SETUP_L, S_E_L, S_HOLD_L, S_WAIT, S_IDLE
  } state_e;

  // Steps 0-3 are single init nibbles, 4-7 init command bytes, 8 means user traffic.
  function automatic logic [7:0] init_byte(input logic [3:0] step);
    case (step)
      4'd0, 4'd1, 4'd2: init_byte = 8'h30;
      4'd3:             init_byte = 8'h20;
      4'd4:             init_byte = 8'h28;
      4'd5:             init_byte = 8'h06;
      4'd6:             init_byte = 8'h0C;
      default:          init_byte = 8'h01;
    endcase
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     step_q, step_d;
  logic [7:0]     data_q, data_d;
  logic           rs_q, rs_d;
  logic [3:0]     sf_q, sf_d_d;
  logic           init_done_q, init_done_d;
  int             dur;
  int             wait_len;
  logic           expire;
  logic           is_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWRON;
      cnt_q       <= '0;
      step_q      <= '0;
      data_q      <= '0;
      rs_q        <= 1'b0;
      sf_q        <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      sf_q        <= sf_d_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    is_clear = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
    case (step_q)
      4'd0:       wait_len = T_INIT1;
      4'd1:       wait_len = T_INIT2;
      4'd2, 4'd3: wait_len = T_CMD;
      default:    wait_len = is_clear ? T_CLEAR : T_CMD;
    endcase

    case (state_q)
      S_PWRON:              dur = T_PWRON;
      S_SETUP_H, S_SETUP_L: dur = T_SETUP;
      S_E_H, S_E_L:         dur = T_EHIGH;
      S_HOLD_H, S_HOLD_L:   dur = T_HOLD;
      S_GAP:                dur = T_NIBGAP;
      S_WAIT:               dur = wait_len;
      default:              dur = 1;
    endcase
    expire = (cnt_q == CW'(dur - 1));
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    cnt_d       = (expire || state_q == S_IDLE) ? '0 : CW'(cnt_q + 1'b1);

    case (state_q)
      S_PWRON: if (expire) begin
        state_d = S_SETUP_H;
        step_d  = '0;
        data_d  = init_byte(4'd0);
        rs_d    = 1'b0;
      end
      S_SETUP_H: if (expire) state_d = S_E_H;
      S_E_H:     if (expire) state_d = S_HOLD_H;
      S_HOLD_H:  if (expire) state_d = (step_q < 4'd4) ? S_WAIT : S_GAP;
      S_GAP:     if (expire) state_d = S_SETUP_L;
      S_SETUP_L: if (expire) state_d = S_E_L;
      S_E_L:     if (expire) state_d = S_HOLD_L;
      S_HOLD_L:  if (expire) state_d = S_WAIT;
      S_WAIT: if (expire) begin
        if (step_q == 4'd7) begin
          state_d     = S_IDLE;
          step_d      = 4'd8;
          init_done_d = 1'b1;
        end else if (step_q < 4'd7) begin
          state_d = S_SETUP_H;
          step_d  = 4'(step_q + 4'd1);
          data_d  = init_byte(4'(step_q + 4'd1));
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: if (in_valid && init_done_q) begin
        state_d = S_SETUP_H;
        data_d  = in_data;
        rs_d    = in_rs;
      end
      default: state_d = S_PWRON;
    endcase

    // Nibble follows the next state so it is already valid on the first SETUP cycle.
    case (state_d)
      S_SETUP_H, S_E_H, S_HOLD_H: sf_d_d = data_d[7:4];
      S_SETUP_L, S_E_L, S_HOLD_L: sf_d_d = data_d[3:0];
      default:                    sf_d_d = sf_q;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) && init_done_q;
  assign init_done = init_done_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = (state_q == S_E_H) || (state_q == S_E_L);
  assign sf_d      = sf_q;

endmodule
